// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - LSU_WIDTH : default data/address width (only 32 is supported)
//   - OP_*      : memory operation encodings carried on op_i
//   - state_e   : LSU control state (IDLE / REQ / RESP)
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int LSU_WIDTH = 32;

    // Memory op encodings; 3, 6 and 7 are illegal, BU/HU are loads only.
    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd4;
    localparam logic [2:0] OP_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
// Ports:
//   we     in   1=store, 0=load
//   op     in   memory op (cpu_pkg OP_*)
//   boff   in   byte offset, addr[1:0]
//   wdata  in   right-aligned store data
//   rword  in   word returned by memory
//   bad    out  misaligned access or illegal op/direction combination
//   wstrb  out  byte strobes for the op (only meaningful for stores)
//   wrep   out  store data replicated across all lanes of its size
//   ldata  out  selected load lane, sign- or zero-extended
// -----------------------------------------------------------------------------
module lsu_align
    import cpu_pkg::*;
#(
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic             we,
    input  logic [2:0]       op,
    input  logic [1:0]       boff,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rword,
    output logic             bad,
    output logic [3:0]       wstrb,
    output logic [WIDTH-1:0] wrep,
    output logic [WIDTH-1:0] ldata
);

    logic [WIDTH-1:0] lane;

    always_comb begin
        bad   = 1'b0;
        wstrb = 4'b0000;
        wrep  = '0;
        ldata = '0;
        // Bring the addressed byte/halfword down to bit 0.
        lane  = rword >> {boff, 3'b000};

        case (op)
            OP_B: begin
                wstrb = 4'b0001 << boff;
                wrep  = {4{wdata[7:0]}};
                ldata = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            end
            OP_H: begin
                bad   = boff[0];
                wstrb = 4'b0011 << {boff[1], 1'b0};
                wrep  = {2{wdata[15:0]}};
                ldata = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            end
            OP_W: begin
                bad   = |boff;
                wstrb = 4'b1111;
                wrep  = wdata;
                ldata = rword;
            end
            OP_BU: begin
                bad   = we;
                ldata = {{(WIDTH-8){1'b0}}, lane[7:0]};
            end
            OP_HU: begin
                bad   = we | boff[0];
                ldata = {{(WIDTH-16){1'b0}}, lane[15:0]};
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Memory-stage load/store unit. Uses the ALU result as byte address, runs one
// word-wide req/ack memory transaction per op and returns extended load data.
// Optional build macro: LSU_TIMEOUT_EN adds a TIMEOUT-cycle ack watchdog.
//
// Handshake: upstream presents an op with valid_i and holds it stable while
// busy_o=1; the op is finished in the single cycle where done_o=1 (busy_o=0
// there) and upstream advances at the end of that cycle. On the memory side
// mem_req_o and all mem_* outputs stay constant until the cycle mem_ack_i=1,
// which also carries mem_rdata_i; ack outside an outstanding request is ignored.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   valid_i/we_i/op_i    op present, store select, op encoding
//   addr_i/wdata_i       byte address, right-aligned store data
//   busy_o               pipeline stall
//   done_o/err_o         completion pulse, error qualifier
//   rdata_o              extended load data (0 for stores and errors)
//   mem_*                word-wide data-memory port
//   dbg_state_o          current control state
// -----------------------------------------------------------------------------
module lsu_mem_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH   = LSU_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             we_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [3:0]       mem_wstrb_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic             mem_ack_i,
    output state_e           dbg_state_o
);

    state_e           state_q, state_d;
    logic             we_q;
    logic [2:0]       op_q;
    logic [1:0]       boff_q;
    logic             err_q;
    logic [WIDTH-1:0] rdata_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [3:0]       mem_wstrb_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic             accept, reject, finish_ok, finish_to;

    // One aligner serves both phases: in IDLE it sees the incoming op (checks,
    // strobes, replication); afterwards it sees the latched op for extraction.
    logic             a_we;
    logic [2:0]       a_op;
    logic [1:0]       a_boff;
    logic             a_bad;
    logic [3:0]       a_wstrb;
    logic [WIDTH-1:0] a_wrep, a_ldata;

    always_comb begin
        a_we   = we_q;
        a_op   = op_q;
        a_boff = boff_q;
        if (state_q == IDLE) begin
            a_we   = we_i;
            a_op   = op_i;
            a_boff = addr_i[1:0];
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .we    (a_we),
        .op    (a_op),
        .boff  (a_boff),
        .wdata (wdata_i),
        .rword (mem_rdata_i),
        .bad   (a_bad),
        .wstrb (a_wstrb),
        .wrep  (a_wrep),
        .ldata (a_ldata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q;
    logic          to_hit;

    assign to_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cnt_q <= '0;
        end else if (state_q == REQ && !mem_ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    logic to_hit;
    assign unused_timeout = (TIMEOUT > 0);
    assign to_hit         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        rdata_o   = '0;
        mem_req_o = 1'b0;

        case (state_q)
            IDLE: begin
                busy_o = valid_i & ~rst;
                if (valid_i) begin
                    if (a_bad) begin
                        reject  = 1'b1;
                        state_d = RESP;
                    end else begin
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                busy_o    = ~rst;
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    finish_ok = 1'b1;
                    state_d   = RESP;
                end else if (to_hit) begin
                    finish_to = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // Reset in this cycle swallows the completion.
                done_o  = ~rst;
                err_o   = err_q & ~rst;
                rdata_o = rst ? '0 : rdata_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            op_q        <= 3'd0;
            boff_q      <= 2'd0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                we_q        <= we_i;
                op_q        <= op_i;
                boff_q      <= addr_i[1:0];
                err_q       <= 1'b0;
                rdata_q     <= '0;
                mem_we_q    <= we_i;
                mem_addr_q  <= {addr_i[WIDTH-1:2], 2'b00};
                mem_wstrb_q <= we_i ? a_wstrb : 4'b0000;
                mem_wdata_q <= we_i ? a_wrep : '0;
            end
            if (reject || finish_to) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (finish_ok) begin
                err_q   <= 1'b0;
                rdata_q <= we_q ? '0 : a_ldata;
            end
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign mem_wdata_o = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed bench for lsu_mem_stage: loads/stores of every size, misaligned and
// illegal ops, ack wait states, ack outside REQ, reset in REQ and RESP, valid
// dropped mid-transaction, and (with LSU_TIMEOUT_EN) the ack watchdog.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;
    import cpu_pkg::*;

`ifdef LSU_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int ACK_WAIT   = 2;
`else
    localparam int TB_TIMEOUT = 16;
    localparam int ACK_WAIT   = 5;
`endif

    logic        clk, rst;
    logic        valid_i, we_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i;
    state_e      dbg_state_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    lsu_mem_stage #(.WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .we_i        (we_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one complete op from IDLE back to IDLE, checked cycle by cycle
    task automatic run_op(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int wait_cycles,
                          input bit drop_valid, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_mwdata);
        logic [31:0] exp;
        valid_i     = 1'b1;
        we_i        = we;
        op_i        = op;
        addr_i      = addr;
        wdata_i     = wdata;
        mem_rdata_i = rword;
        exp_q.push_back(exp_rdata);
        #1;
        check({tag, ".busy_idle"}, busy_o, 1);
        check({tag, ".req_idle"}, mem_req_o, 0);
        tick();
        if (exp_err) begin
            check({tag, ".done"}, done_o, 1);
            check({tag, ".err"}, err_o, 1);
            check({tag, ".req"}, mem_req_o, 0);
            check({tag, ".busy"}, busy_o, 0);
            exp = exp_q.pop_front();
            check({tag, ".rdata"}, rdata_o, exp);
        end else begin
            check({tag, ".req"}, mem_req_o, 1);
            check({tag, ".busy_req"}, busy_o, 1);
            check({tag, ".done_req"}, done_o, 0);
            check({tag, ".maddr"}, mem_addr_o, exp_maddr);
            check({tag, ".wstrb"}, mem_wstrb_o, exp_strb);
            check({tag, ".mwdata"}, mem_wdata_o, exp_mwdata);
            check({tag, ".mwe"}, mem_we_o, we);
            if (drop_valid) valid_i = 1'b0;
            for (int i = 0; i < wait_cycles; i++) begin
                tick();
                check({tag, ".req_wait"}, mem_req_o, 1);
                check({tag, ".maddr_wait"}, mem_addr_o, exp_maddr);
                check({tag, ".done_wait"}, done_o, 0);
            end
            mem_ack_i = 1'b1;
            tick();
            mem_ack_i = 1'b0;
            check({tag, ".done"}, done_o, 1);
            check({tag, ".err"}, err_o, 0);
            check({tag, ".busy_resp"}, busy_o, 0);
            check({tag, ".req_resp"}, mem_req_o, 0);
            exp = exp_q.pop_front();
            check({tag, ".rdata"}, rdata_o, exp);
        end
        valid_i = 1'b0;
        tick();
        check({tag, ".done_after"}, done_o, 0);
        check({tag, ".state_after"}, dbg_state_o, IDLE);
    endtask

    initial begin
        rst         = 1'b1;
        valid_i     = 1'b0;
        we_i        = 1'b0;
        op_i        = 3'd0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        tick();
        tick();
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);
        check("rst.err", err_o, 0);
        check("rst.rdata", rdata_o, 0);
        check("rst.req", mem_req_o, 0);
        check("rst.mwe", mem_we_o, 0);
        check("rst.maddr", mem_addr_o, 0);
        check("rst.wstrb", mem_wstrb_o, 0);
        check("rst.mwdata", mem_wdata_o, 0);
        check("rst.state", dbg_state_o, IDLE);
        rst = 1'b0;
        tick();

        // stray ack while idle
        mem_ack_i = 1'b1;
        tick();
        check("ack_idle.done", done_o, 0);
        check("ack_idle.req", mem_req_o, 0);
        check("ack_idle.state", dbg_state_o, IDLE);
        mem_ack_i = 1'b0;
        tick();

        // loads                 we    op     addr          wdata  rword        wait drop err rdata         maddr         strb  mwdata
        run_op("lw",      1'b0, OP_W,  32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0000_0100, 4'h0, 32'h0);
        run_op("lb",      1'b0, OP_B,  32'h0000_0103, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 32'hFFFFFF80, 32'h0000_0100, 4'h0, 32'h0);
        run_op("lbu",     1'b0, OP_BU, 32'h0000_0103, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 32'h00000080, 32'h0000_0100, 4'h0, 32'h0);
        run_op("lhu",     1'b0, OP_HU, 32'h0000_0102, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 32'h000080FF, 32'h0000_0100, 4'h0, 32'h0);
        run_op("lh",      1'b0, OP_H,  32'h0000_0100, 32'h0, 32'h12348001, 0, 0, 1'b0, 32'hFFFF8001, 32'h0000_0100, 4'h0, 32'h0);
        // stores
        run_op("sb",      1'b1, OP_B,  32'h0000_0201, 32'h000000AB, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0, 32'h0000_0200, 4'b0010, 32'hABABABAB);
        run_op("sh",      1'b1, OP_H,  32'h0000_0202, 32'h0000BEEF, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0, 32'h0000_0200, 4'b1100, 32'hBEEFBEEF);
        run_op("sw",      1'b1, OP_W,  32'h0000_0300, 32'h12345678, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0, 32'h0000_0300, 4'b1111, 32'h12345678);
        // misaligned / illegal
        run_op("lw_mis",  1'b0, OP_W,  32'h0000_0102, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        run_op("sh_mis",  1'b1, OP_H,  32'h0000_0101, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        run_op("op3",     1'b0, 3'd3,  32'h0000_0100, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        run_op("sbu_ill", 1'b1, OP_BU, 32'h0000_0100, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        // wait states, valid dropped mid-request
        run_op("lw_wait", 1'b0, OP_W,  32'h0000_0400, 32'h0, 32'hCAFEF00D, ACK_WAIT, 0, 1'b0, 32'hCAFEF00D, 32'h0000_0400, 4'h0, 32'h0);
        run_op("lb_drop", 1'b0, OP_B,  32'h0000_0101, 32'h0, 32'h00007F00, 1, 1, 1'b0, 32'h0000007F, 32'h0000_0100, 4'h0, 32'h0);

        // reset while in REQ; later ack must be ignored
        valid_i = 1'b1; we_i = 1'b0; op_i = OP_W; addr_i = 32'h0000_0600;
        tick();
        check("rstreq.req", mem_req_o, 1);
        tick();
        rst = 1'b1;
        valid_i = 1'b0;
        tick();
        check("rstreq.req_after", mem_req_o, 0);
        check("rstreq.busy", busy_o, 0);
        check("rstreq.state", dbg_state_o, IDLE);
        rst = 1'b0;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("rstreq.done_late", done_o, 0);
        check("rstreq.req_late", mem_req_o, 0);
        tick();
        check("rstreq.done_late2", done_o, 0);

        // reset while in RESP suppresses done
        valid_i = 1'b1; we_i = 1'b0; op_i = OP_W; addr_i = 32'h0000_0700;
        mem_rdata_i = 32'h55AA55AA;
        tick();
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("rstresp.state", dbg_state_o, RESP);
        rst = 1'b1;
        #1;
        check("rstresp.done", done_o, 0);
        check("rstresp.rdata", rdata_o, 0);
        valid_i = 1'b0;
        tick();
        rst = 1'b0;
        check("rstresp.state_after", dbg_state_o, IDLE);
        tick();
        check("rstresp.done_after", done_o, 0);

`ifdef LSU_TIMEOUT_EN
        // no ack: request held TIMEOUT cycles, then error completion
        valid_i = 1'b1; we_i = 1'b0; op_i = OP_W; addr_i = 32'h0000_0800;
        tick();
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            check("to.req", mem_req_o, 1);
            check("to.done_wait", done_o, 0);
            tick();
        end
        check("to.req_drop", mem_req_o, 0);
        check("to.done", done_o, 1);
        check("to.err", err_o, 1);
        check("to.rdata", rdata_o, 0);
        valid_i = 1'b0;
        tick();
        check("to.done_after", done_o, 0);
`endif

        check("scoreboard.empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit, directly downstream of the execute ALU.
- Takes the ALU result as the effective byte address. Drives a word-wide req/ack data-memory port with byte strobes. Returns sign- or zero-extended load data.
- Holds the pipeline through a stall output while a memory transaction is outstanding.

Parameters:
- WIDTH, 32, data/address width. Only 32 is supported because strobes are fixed at 4 byte lanes.
- TIMEOUT, 16, maximum cycles to wait for mem_ack_i. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  memory op present; held stable by upstream while busy_o=1
- we_i  in  1  1=store, 0=load
- op_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU; 3,6,7 illegal; BU/HU are loads only
- addr_i  in  WIDTH  byte address (ALU result)
- wdata_i  in  WIDTH  store data, right-aligned
- busy_o  out  1  stall request to pipeline
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  with done_o: misaligned/illegal op (or timeout)
- rdata_o  out  WIDTH  extended load data, valid when done_o=1
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  WIDTH  word address, bits [1:0] = 0
- mem_wstrb_o  out  4  byte write strobes
- mem_wdata_o  out  WIDTH  lane-replicated store data
- mem_rdata_i  in  WIDTH  read word
- mem_ack_i  in  1  transaction complete; rdata valid in the same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state=IDLE.
- States: IDLE, REQ, RESP.
- IDLE:
  - busy_o = valid_i.
  - valid_i and legal/aligned: latch we, op, addr, wdata; go to REQ.
  - valid_i and misaligned/illegal: go to RESP with err flag; no memory request.
- REQ:
  - mem_req_o=1, busy_o=1; all mem_* outputs are registered and stable until ack.
  - On mem_ack_i: capture the extended load data; go to RESP.
- RESP:
  - done_o=1, busy_o=0, err_o per flag. rdata_o is 0 for stores and errors.
  - Go unconditionally to IDLE. valid_i is ignored in this state: it is the same op, and upstream advances at the end of this cycle.
- Latency:
  - Aligned op with ack in the first REQ cycle: done_o 2 cycles after acceptance (IDLE, REQ, RESP).
  - Each extra wait cycle adds 1.
  - Misaligned/illegal op: done_o in the next cycle.
- Alignment:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=0.
  - Store with op 4 or 5 is illegal.
- Store strobes: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
- Store data: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W as-is.
- Loads:
  - mem_wstrb_o=0.
  - Selected lane = mem_rdata_i >> (addr[1:0]*8).
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- mem_addr_o = {addr[WIDTH-1:2],2'b00}.
- Boundary conditions:
  - mem_ack_i outside REQ is ignored.
  - rst in REQ: mem_req_o=0 after that edge; a late ack is ignored.
  - rst in RESP: done_o is suppressed.
  - valid_i deasserted while in REQ (protocol violation): the transaction still completes; done_o still pulses.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter of width $clog2(TIMEOUT+1), cleared on entering REQ, increments each REQ cycle without ack.
  - At count==TIMEOUT-1 without ack: drop mem_req_o, go to RESP with err_o=1, rdata_o=0.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - op encodings: OP_B, OP_H, OP_W, OP_BU, OP_HU
  - state enum: IDLE/REQ/RESP
  - WIDTH default
- One natural sub-module, lsu_align: combinational strobe generation, store-lane replication, load extraction and extension, misalign/illegal detection. The FSM stays in the top module.

Test Plan:
- LW at addr 0x100, mem_rdata_i=0xDEADBEEF, ack on first REQ cycle:
  - mem_addr_o=0x100, mem_wstrb_o=0, done_o 2 cycles after accept
  - rdata_o=0xDEADBEEF; busy_o high for exactly 2 cycles
- LB at addr 0x103, word 0x80FF1234 -> rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SB wdata 0x000000AB at 0x201:
  - mem_addr_o=0x200, wstrb=4'b0010, mem_wdata_o=0xABABABAB, mem_we_o=1
  - SH at 0x202 -> wstrb=4'b1100.
- LW at 0x102 and SH at 0x101:
  - no mem_req_o; done_o and err_o the next cycle; rdata_o=0
  - op_i=3 behaves the same.
- Ack withheld 5 cycles: mem_req_o and mem_addr_o stable for 6 REQ cycles, done_o one cycle after ack. Assert rst during REQ in a second run: mem_req_o low after that edge, later ack ignored, no done_o.
- With LSU_TIMEOUT_EN, TIMEOUT=4, no ack: mem_req_o high 4 cycles, then done_o=1, err_o=1.
